// File: rtl/fft_framer_pkg.sv
`default_nettype none
// fft_framer_pkg: default sizes, FSM state type and the Hann window table for fft_framer.
// The window table is only referenced when FFT_FRAMER_WINDOW_EN is defined.
package fft_framer_pkg;

    localparam int N_DEF        = 64;
    localparam int LOG_N_DEF    = 6;
    localparam int HOP_DEF      = 32;
    localparam int IN_WIDTH_DEF = 16;
    localparam int WIDTH_DEF    = 32;
    localparam int COEF_W       = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    typedef logic [LOG_N_DEF:0] ptr_t;

    // Unsigned Q1.15 Hann coefficients for N=64; the window is symmetric about k=32.
    function automatic logic [COEF_W-1:0] hann_coef(input logic [LOG_N_DEF-1:0] k);
        logic [LOG_N_DEF-1:0] j;
        logic [COEF_W-1:0]    w;
        j = (k > 6'd32) ? (6'd0 - k) : k;
        case (j)
            6'd0:    w = 16'd0;
            6'd1:    w = 16'd79;
            6'd2:    w = 16'd315;
            6'd3:    w = 16'd705;
            6'd4:    w = 16'd1247;
            6'd5:    w = 16'd1935;
            6'd6:    w = 16'd2761;
            6'd7:    w = 16'd3719;
            6'd8:    w = 16'd4799;
            6'd9:    w = 16'd5990;
            6'd10:   w = 16'd7281;
            6'd11:   w = 16'd8660;
            6'd12:   w = 16'd10114;
            6'd13:   w = 16'd11628;
            6'd14:   w = 16'd13187;
            6'd15:   w = 16'd14778;
            6'd16:   w = 16'd16384;
            6'd17:   w = 16'd17989;
            6'd18:   w = 16'd19580;
            6'd19:   w = 16'd21139;
            6'd20:   w = 16'd22653;
            6'd21:   w = 16'd24107;
            6'd22:   w = 16'd25486;
            6'd23:   w = 16'd26777;
            6'd24:   w = 16'd27968;
            6'd25:   w = 16'd29048;
            6'd26:   w = 16'd30006;
            6'd27:   w = 16'd30832;
            6'd28:   w = 16'd31520;
            6'd29:   w = 16'd32062;
            6'd30:   w = 16'd32452;
            6'd31:   w = 16'd32688;
            6'd32:   w = 16'd32767;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/framer_ram.sv
`default_nettype none
// framer_ram: simple dual-port sample store, one write port and one synchronous read port.
module framer_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fft_framer.sv
`default_nettype none
// fft_framer: buffers a real sample stream and emits overlapping N-sample complex frames.
// Define FFT_FRAMER_WINDOW_EN to apply a Hann window (adds one cycle of latency).
module fft_framer
    import fft_framer_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int LOG_N    = LOG_N_DEF,
    parameter int HOP      = HOP_DEF,
    parameter int IN_WIDTH = IN_WIDTH_DEF,
    parameter int WIDTH    = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_in_en,
    input  logic [IN_WIDTH-1:0] sample_in,
    output logic                data_out_en,
    output logic [WIDTH-1:0]    data_out_re,
    output logic [WIDTH-1:0]    data_out_im,
    output logic                frame_start,
    output logic                overrun
);

    localparam int              AW        = LOG_N + 1;
    localparam logic [AW-1:0]   FILL_FULL = AW'(N);
    localparam logic [AW-1:0]   HOP_LAST  = AW'(HOP);
    localparam logic [LOG_N-1:0] IDX_LAST = LOG_N'(N - 1);

    state_t              state_q;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       fill_q, fill_d;
    logic [AW-1:0]       hop_cnt_q, hop_cnt_d;
    logic [AW-1:0]       base_q, pend_base_q, new_base, rd_addr;
    logic [LOG_N-1:0]    idx_q;
    logic                first_done_q, pending_q, overrun_q;
    logic                out_en_q, out_fs_q;
    logic                trigger, rd_en;
    logic [IN_WIDTH-1:0] rd_data;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        fill_d    = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        hop_cnt_d = (hop_cnt_q == FILL_FULL) ? hop_cnt_q : hop_cnt_q + 1'b1;
        trigger   = sample_in_en && (fill_d == FILL_FULL)
                    && (!first_done_q || (hop_cnt_d == HOP_LAST));
        new_base  = wr_ptr_d - FILL_FULL;
        rd_addr   = base_q + AW'(idx_q);
        rd_en     = (state_q == EMIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            hop_cnt_q    <= '0;
            first_done_q <= 1'b0;
            idx_q        <= '0;
            base_q       <= '0;
            pend_base_q  <= '0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            out_en_q     <= 1'b0;
            out_fs_q     <= 1'b0;
        end else begin
            if (sample_in_en) begin
                wr_ptr_q  <= wr_ptr_d;
                fill_q    <= fill_d;
                hop_cnt_q <= trigger ? '0 : hop_cnt_d;
            end
            if (trigger) begin
                first_done_q <= 1'b1;
            end
            out_en_q <= (state_q == EMIT);
            out_fs_q <= (state_q == EMIT) && (idx_q == '0);

            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        state_q <= EMIT;
                        idx_q   <= '0;
                        base_q  <= new_base;
                    end
                end
                EMIT: begin
                    if (trigger && pending_q) begin
                        overrun_q <= 1'b1;
                    end
                    // A trigger on the last read with nothing pending chains straight into its frame.
                    if (idx_q == IDX_LAST) begin
                        idx_q <= '0;
                        if (pending_q) begin
                            base_q    <= pend_base_q;
                            pending_q <= 1'b0;
                        end else if (trigger) begin
                            base_q <= new_base;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (trigger && !pending_q) begin
                            pending_q   <= 1'b1;
                            pend_base_q <= new_base;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    framer_ram #(
        .DEPTH (2 * N),
        .AW    (AW),
        .DW    (IN_WIDTH)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (sample_in_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (sample_in),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign overrun     = overrun_q;
    assign data_out_im = '0;

`ifdef FFT_FRAMER_WINDOW_EN
    logic [LOG_N-1:0]                rd_idx_q;
    logic [COEF_W-1:0]               coef;
    logic signed [IN_WIDTH+COEF_W:0] prod, prod_rnd;
    logic [WIDTH-1:0]                win_q;
    logic                            win_en_q, win_fs_q;

    always_comb begin
        coef     = hann_coef(rd_idx_q);
        prod     = $signed(rd_data) * $signed({1'b0, coef});
        prod_rnd = prod + $signed((IN_WIDTH + COEF_W + 1)'(1 << 14));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_idx_q <= '0;
            win_q    <= '0;
            win_en_q <= 1'b0;
            win_fs_q <= 1'b0;
        end else begin
            rd_idx_q <= idx_q;
            win_en_q <= out_en_q;
            win_fs_q <= out_fs_q;
            win_q    <= out_en_q ? WIDTH'(prod_rnd >>> 15) : '0;
        end
    end

    assign data_out_en = win_en_q;
    assign data_out_re = win_en_q ? win_q : '0;
    assign frame_start = win_en_q & win_fs_q;
`else
    assign data_out_en = out_en_q;
    assign data_out_re = out_en_q ? {{(WIDTH-IN_WIDTH){rd_data[IN_WIDTH-1]}}, rd_data} : '0;
    assign frame_start = out_en_q & out_fs_q;
`endif

endmodule
`default_nettype wire
